// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register file slice: default geometry,
//   the register index type and the hardwired-zero register index.
package regfile_pkg;

    localparam int REGFILE_DATA_WIDTH = 64;
    localparam int REGFILE_NUM_REGS   = 32;
    localparam int REGFILE_ADDR_WIDTH = $clog2(REGFILE_NUM_REGS);

    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_idx_t;

    // Register 0 is never stored, never marked busy and always reads 0.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_busy_tracker.sv
// regfile_busy_tracker
//   Per-register busy scoreboard. Issue sets a bit with a claim and
//   writeback clears it. A claim and a writeback to the same register in
//   the same cycle leave the bit set, because the claim represents a newer
//   writer that is still in flight.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   wr_en        : writeback strobe, clears busy[wr_addr]
//   wr_addr      : writeback index
//   claim_en     : issue strobe, sets busy[claim_addr]
//   claim_addr   : claimed index
//   busy         : registered busy vector (bit 0 is always 0)
//   busy_count   : registered number of set bits in busy
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = REGFILE_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  claim_en,
    input  logic [ADDR_WIDTH-1:0] claim_addr,
    output logic [NUM_REGS-1:0]   busy,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0] busyNext;
    logic [ADDR_WIDTH:0] countNext;

    // Clear first, then set, so a same-cycle claim overrides the writeback.
    always_comb begin
        busyNext = busy;
        if (wr_en && (wr_addr != ZERO_IDX)) begin
            busyNext[wr_addr] = 1'b0;
        end
        if (claim_en && (claim_addr != ZERO_IDX)) begin
            busyNext[claim_addr] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Count is taken from the next-state vector so the registered count
    // always matches the registered busy vector.
    always_comb begin
        countNext = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            countNext = countNext + (ADDR_WIDTH+1)'(busyNext[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busyNext;
            busy_count <= countNext;
        end
    end

endmodule

// File: rtl/regfile_scoreboard_nr.sv
// regfile_scoreboard_nr
//   Multi-read-port integer register file with write-through bypass,
//   hardwired-zero register 0 and a per-register busy scoreboard.
//
//   wr_en and claim_en are single-cycle strobes without a ready signal:
//   every request presented on a rising edge is accepted on that edge.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   rd_en        : per-port read enable (NUM_READ bits)
//   rd_addr      : per-port read index, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data      : registered read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy      : combinational operand hazard per port
//   wr_en        : writeback valid
//   wr_addr      : writeback index
//   wr_data      : writeback value
//   claim_en     : issue claims a destination register
//   claim_addr   : claimed index
//   busy_count   : registered number of busy registers
module regfile_scoreboard_nr
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int NUM_REGS   = REGFILE_NUM_REGS,
    parameter int NUM_READ   = 2,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           claim_en,
    input  logic [ADDR_WIDTH-1:0]          claim_addr,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    // Entry 0 is cleared by reset and never written, so it is a constant
    // that synthesis removes; reads of index 0 are forced to 0 anyway.
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic                  wrValid;

    assign wrValid = wr_en && (wr_addr != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wrValid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    regfile_busy_tracker #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) busyTracker (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy       (busy),
        .busy_count (busy_count)
    );

    for (genvar p = 0; p < NUM_READ; p++) begin : gRead
        logic [ADDR_WIDTH-1:0] addr;
        logic                  bypassHit;
        logic [DATA_WIDTH-1:0] readValue;
        logic [DATA_WIDTH-1:0] dataQ;

        assign addr      = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        // wrValid already excludes index 0, so a hit implies addr != 0.
        assign bypassHit = wrValid && (wr_addr == addr);

        always_comb begin
            if (addr == ZERO_IDX) begin
                readValue = '0;
            end else if (bypassHit) begin
                readValue = wr_data;
            end else begin
                readValue = mem[addr];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dataQ <= '0;
            end else if (rd_en[p]) begin
                dataQ <= readValue;
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = dataQ;
        // A writeback landing this cycle is forwarded by the bypass, so it
        // no longer blocks the operand.
        assign rd_busy[p] = busy[addr] & ~bypassHit;
    end

endmodule

// File: tb/tb_regfile_scoreboard_nr.sv
module tb_regfile_scoreboard_nr;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam int NP = 3;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic [AW:0]      busy_count;

    regfile_scoreboard_nr #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_READ   (NP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_count (busy_count)
    );

    // ---------------- scoreboard ----------------
    int checkCount = 0;
    int passCount  = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compares all three ports against the expected queue (port 0 first).
    task automatic checkPorts(input string name);
        logic [DW-1:0] e;
        for (int p = 0; p < NP; p++) begin
            e = exp_q.pop_front();
            check($sformatf("%s rd_data[%0d]", name, p), rd_data[p*DW +: DW], e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic [2:0] en,
                         input int a0, input int a1, input int a2,
                         input logic we, input int wa, input logic [DW-1:0] wd,
                         input logic ce, input int ca);
        reset      = rst;
        rd_en      = en;
        rd_addr    = {AW'(a2), AW'(a1), AW'(a0)};
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        claim_en   = ce;
        claim_addr = AW'(ca);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]    en;
        int            a0, a1, a2;
        logic          we;
        int            wa;
        logic [DW-1:0] wd;
        logic          ce;
        int            ca;
        logic [2:0]    expBusy;   // sampled before the edge
        logic [DW-1:0] e0, e1, e2; // sampled after the edge
        int            expCnt;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [2:0] en, input int a0, input int a1, input int a2,
                          input logic we, input int wa, input logic [DW-1:0] wd,
                          input logic ce, input int ca, input logic [2:0] eb,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                          input logic [DW-1:0] e2, input int ec);
        vec_t v;
        v.en = en; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.we = we; v.wa = wa; v.wd = wd; v.ce = ce; v.ca = ca;
        v.expBusy = eb; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.expCnt = ec;
        vecs.push_back(v);
    endtask

    localparam logic [DW-1:0] DEAD = 64'hDEAD_BEEF_0000_0001;
    localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        //      en      a0 a1 a2 we wa wd       ce ca busy    e0    e1    e2    cnt
        addVec(3'b001, 5, 0, 0, 1, 5, DEAD,    0, 0, 3'b000, DEAD, 0,    0,    0); // write+bypass r5
        addVec(3'b000, 0, 0, 0, 0, 0, 0,       0, 0, 3'b000, DEAD, 0,    0,    0); // hold
        addVec(3'b110, 0, 5, 5, 0, 0, 0,       0, 0, 3'b000, DEAD, DEAD, DEAD, 0); // r5 from array
        addVec(3'b001, 0, 0, 0, 1, 0, ONES,    0, 0, 3'b000, 0,    DEAD, DEAD, 0); // write r0 ignored
        addVec(3'b000, 0, 0, 0, 0, 0, 0,       1, 0, 3'b000, 0,    DEAD, DEAD, 0); // claim r0 ignored
        addVec(3'b111, 0, 0, 0, 0, 0, 0,       0, 0, 3'b000, 0,    0,    0,    0); // read r0
        addVec(3'b000, 7, 0, 0, 0, 0, 0,       1, 7, 3'b000, 0,    0,    0,    1); // claim r7
        addVec(3'b001, 7, 0, 0, 0, 0, 0,       0, 0, 3'b001, 0,    0,    0,    1); // r7 busy
        addVec(3'b011, 7, 7, 0, 1, 7, 42,      1, 7, 3'b000, 42,   42,   0,    1); // wb+claim r7
        addVec(3'b001, 7, 7, 0, 0, 0, 0,       0, 0, 3'b011, 42,   42,   0,    1); // busy again
        addVec(3'b100, 7, 7, 7, 1, 7, 100,     0, 0, 3'b000, 42,   42,   100,  0); // wb r7 clears
        addVec(3'b101, 3, 4, 3, 1, 3, 64'h55,  1, 4, 3'b000, 64'h55, 42, 64'h55, 1); // wb non-busy r3
        addVec(3'b010, 3, 4, 3, 0, 0, 0,       1, 4, 3'b010, 64'h55, 0,  64'h55, 1); // re-claim r4
        addVec(3'b000, 0, 0, 0, 1, 9, 64'h1234, 0, 0, 3'b000, 64'h55, 0, 64'h55, 1); // write r9
        addVec(3'b101, 9, 9, 9, 0, 0, 0,       0, 0, 3'b000, 64'h1234, 0, 64'h1234, 1); // en 101
        addVec(3'b111, 9, 9, 9, 0, 0, 0,       0, 0, 3'b000, 64'h1234, 64'h1234, 64'h1234, 1);
        addVec(3'b000, 4, 4, 4, 1, 4, 7,       0, 0, 3'b000, 64'h1234, 64'h1234, 64'h1234, 0); // wb r4
    end

    // ---------------- test sequence ----------------
    initial begin
        drive(1'b1, 3'b000, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy_count", DW'(busy_count), 0);
        for (int p = 0; p < NP; p++) exp_q.push_back('0);
        checkPorts("reset");

        // Read every register after reset.
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            drive(1'b0, 3'b111, i, (i + 1) % NR, (i + 2) % NR, 1'b0, 0, '0, 1'b0, 0);
            #1;
            check($sformatf("post-reset rd_busy r%0d", i), DW'(rd_busy), 0);
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) exp_q.push_back('0);
            checkPorts($sformatf("post-reset read r%0d", i));
            check($sformatf("post-reset busy_count r%0d", i), DW'(busy_count), 0);
        end

        // Table-driven vectors.
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(1'b0, vecs[k].en, vecs[k].a0, vecs[k].a1, vecs[k].a2,
                  vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].ce, vecs[k].ca);
            #1;
            check($sformatf("vec%0d rd_busy", k), DW'(rd_busy), DW'(vecs[k].expBusy));
            @(posedge clk);
            #1;
            exp_q.push_back(vecs[k].e0);
            exp_q.push_back(vecs[k].e1);
            exp_q.push_back(vecs[k].e2);
            checkPorts($sformatf("vec%0d", k));
            check($sformatf("vec%0d busy_count", k), DW'(busy_count), DW'(vecs[k].expCnt));
        end

        // Claims in flight dropped by a mid-operation reset.
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            drive(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, '0, 1'b1, r);
            @(posedge clk);
            #1;
            check($sformatf("claim r%0d busy_count", r), DW'(busy_count), DW'(r));
        end
        @(negedge clk);
        drive(1'b1, 3'b111, 1, 2, 3, 1'b1, 2, 64'hAB, 1'b1, 5);
        #1;
        // r2 writeback resolves port 1; r1 and r3 still busy.
        check("pre-reset rd_busy", DW'(rd_busy), DW'(3'b101));
        @(posedge clk);
        #1;
        check("mid-reset busy_count", DW'(busy_count), 0);
        for (int p = 0; p < NP; p++) exp_q.push_back('0);
        checkPorts("mid-reset");
        @(negedge clk);
        drive(1'b0, 3'b111, 1, 2, 5, 1'b0, 0, '0, 1'b0, 0);
        #1;
        check("after-reset rd_busy", DW'(rd_busy), 0);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) exp_q.push_back('0);
        checkPorts("after-reset read r1/r2/r5");
        check("after-reset busy_count", DW'(busy_count), 0);

        @(negedge clk);
        drive(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
